// File: rtl/maverickOne_pkg.sv
// Core-wide architectural constants shared by the maverickOne pipeline blocks.
package maverickOne_pkg;

    // Architectural register count and machine word width.
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 32;

endpackage : maverickOne_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after the pointer
// (wrapping modulo N) wins. Reusable by any shared-port controller.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int unsigned w_cand;
    logic        w_found;

    // Scan from the pointer position, wrapping once, and grant the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = 32'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && i_req[IW'(w_cand)]) begin
                o_gnt[IW'(w_cand)] = 1'b1;
                o_idx              = IW'(w_cand);
                w_found            = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule : rr_arbiter

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of NUM_SRC writeback requesters per cycle in
// round-robin order and presents the accepted write to the register file
// through a single output register stage. Writes to register 0 are
// handshaken but never strobed; flush suppresses the current-cycle grant only.
module wb_arbiter
    import maverickOne_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    parameter  int unsigned NR      = NUM_REGS,
    parameter  int unsigned DW      = XLEN,
    localparam int unsigned AW      = $clog2(NR),
    localparam int unsigned SW      = $clog2(NUM_SRC)
) (
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  logic                             flush_i,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    input  logic [NUM_SRC-1:0][AW-1:0]       src_addr_i,
    input  logic [NUM_SRC-1:0][DW-1:0]       src_data_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    output logic                             wr_unlock_en_o,
    output logic [AW-1:0]                    wr_unlock_addr_o,
    output logic [DW-1:0]                    wr_unlock_data_o,
    output logic [SW-1:0]                    grant_idx_o
);

    logic [SW-1:0]      r_rr;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_gnt;
    logic [SW-1:0]      w_idx;
    logic               w_any;
    logic [SW-1:0]      w_rr_next;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_data;

    // Requests are masked during flush and while reset is held so no grant leaks out.
    assign w_req = (arst_ni && !flush_i) ? src_valid_i : '0;

    // Round-robin selection starting at the stored pointer.
    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_rr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign src_ready_o = w_gnt;
    assign grant_idx_o = w_idx;
    assign w_sel_addr  = src_addr_i[w_idx];
    assign w_sel_data  = src_data_i[w_idx];

    // Pointer moves just past the winner; explicit wrap keeps non-power-of-two counts correct.
    assign w_rr_next = (w_idx == SW'(NUM_SRC - 1)) ? '0 : w_idx + SW'(1);

    // Round-robin pointer: advances only on an accepted write.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rr <= '0;
        end else if (w_any) begin
            r_rr <= w_rr_next;
        end
    end

    // Output stage: one-cycle strobe per accepted non-zero write; addr/data hold when idle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_unlock_en_o   <= 1'b0;
            wr_unlock_addr_o <= '0;
            wr_unlock_data_o <= '0;
        end else if (w_any) begin
            wr_unlock_en_o   <= (w_sel_addr != '0);
            wr_unlock_addr_o <= w_sel_addr;
            wr_unlock_data_o <= w_sel_data;
        end else begin
            wr_unlock_en_o   <= 1'b0;
        end
    end

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// reset/flush corner sequences and a random phase with a reference model.
module tb_wb_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    logic                    clk_i = 1'b0;
    logic                    arst_ni;
    logic                    flush_i;
    logic [NS-1:0]           src_valid_i;
    logic [NS-1:0][AW-1:0]   src_addr_i;
    logic [NS-1:0][DW-1:0]   src_data_i;
    logic [NS-1:0]           src_ready_o;
    logic                    wr_unlock_en_o;
    logic [AW-1:0]           wr_unlock_addr_o;
    logic [DW-1:0]           wr_unlock_data_o;
    logic [SW-1:0]           grant_idx_o;

    wb_arbiter #(
        .NUM_SRC (NS),
        .NR      (32),
        .DW      (DW)
    ) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .flush_i          (flush_i),
        .src_valid_i      (src_valid_i),
        .src_addr_i       (src_addr_i),
        .src_data_i       (src_data_i),
        .src_ready_o      (src_ready_o),
        .wr_unlock_en_o   (wr_unlock_en_o),
        .wr_unlock_addr_o (wr_unlock_addr_o),
        .wr_unlock_data_o (wr_unlock_data_o),
        .grant_idx_o      (grant_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NS-1:0] valid;
        logic          flush;
        logic [AW-1:0] addr;
        logic [DW-1:0] base;
        logic [NS-1:0] exp_ready;
    } vec_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          chk_ad;
    } wr_t;

    wr_t           sb_q[$];
    vec_t          tbl[19];
    int            n_pass  = 0;
    int            n_total = 0;
    logic [AW-1:0] last_addr  = '0;
    logic [DW-1:0] last_data  = '0;
    logic          last_known = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic [NS-1:0] valid, input logic flush,
                         input logic [AW-1:0] addr, input logic [DW-1:0] base);
        src_valid_i = valid;
        flush_i     = flush;
        for (int i = 0; i < NS; i++) begin
            src_addr_i[i] = addr;
            src_data_i[i] = base + 32'(i);
        end
    endtask

    function automatic logic [SW-1:0] onehot_idx(input logic [NS-1:0] g);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) if (g[i]) r = SW'(i);
        return r;
    endfunction

    function automatic logic [NS-1:0] model_gnt(input logic [NS-1:0] req, input int unsigned ptr);
        int j;
        for (int k = 0; k < NS; k++) begin
            j = int'((ptr + 32'(k)) % NS);
            if (req[j[1:0]]) return NS'(1) << j;
        end
        return '0;
    endfunction

    // Expected register-file write for the cycle just granted (or not).
    task automatic push_expect(input logic [NS-1:0] g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        if (g != '0) begin
            e.en = (a != '0); e.addr = a; e.data = d; e.chk_ad = (a != '0);
            last_addr = a; last_data = d; last_known = (a != '0);
        end else begin
            e.en = 1'b0; e.addr = last_addr; e.data = last_data; e.chk_ad = last_known;
        end
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        wr_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_en"}, 64'(wr_unlock_en_o), 64'(e.en));
        if (e.chk_ad) begin
            check({tag, "_addr"}, 64'(wr_unlock_addr_o), 64'(e.addr));
            check({tag, "_data"}, 64'(wr_unlock_data_o), 64'(e.data));
        end
    endtask

    // One table cycle: drive at posedge+1, retire previous write, check grant, push expectation.
    task automatic run_vec(input vec_t v, input int n);
        logic [SW-1:0] gi;
        string tag;
        tag = $sformatf("vec%0d", n);
        apply(v.valid, v.flush, v.addr, v.base);
        #1;
        if (sb_q.size() != 0) pop_compare(tag);
        #2;
        check({tag, "_ready"}, 64'(src_ready_o), 64'(v.exp_ready));
        gi = onehot_idx(v.exp_ready);
        if (v.exp_ready != '0) check({tag, "_idx"}, 64'(grant_idx_o), 64'(gi));
        push_expect(v.exp_ready, v.addr, v.base + 32'(gi));
        @(posedge clk_i);
        #1;
    endtask

    logic [NS-1:0]  rv;
    logic [AW-1:0]  ra[NS];
    logic [DW-1:0]  rd[NS];
    int unsigned    wt[NS];
    int unsigned    ptr;
    int unsigned    max_wait;

    initial begin
        //           valid    flush addr   base      exp_ready
        tbl[0]  = '{4'b1111, 1'b0, 5'd5, 32'h0A, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 5'd5, 32'h0A, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 5'd5, 32'h0A, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 5'd5, 32'h0A, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 5'd5, 32'h0A, 4'b0001};
        tbl[5]  = '{4'b0100, 1'b0, 5'd7, 32'h53, 4'b0100};
        tbl[6]  = '{4'b0000, 1'b0, 5'd7, 32'h53, 4'b0000};
        tbl[7]  = '{4'b0010, 1'b0, 5'd0, 32'h00, 4'b0010};
        tbl[8]  = '{4'b1111, 1'b0, 5'd3, 32'h10, 4'b0100};
        tbl[9]  = '{4'b0011, 1'b1, 5'd3, 32'h10, 4'b0000};
        tbl[10] = '{4'b1000, 1'b0, 5'd9, 32'h20, 4'b1000};
        tbl[11] = '{4'b0011, 1'b1, 5'd4, 32'h30, 4'b0000};
        tbl[12] = '{4'b0011, 1'b0, 5'd4, 32'h30, 4'b0001};
        tbl[13] = '{4'b0011, 1'b0, 5'd4, 32'h30, 4'b0010};
        tbl[14] = '{4'b0000, 1'b0, 5'd4, 32'h30, 4'b0000};
        tbl[15] = '{4'b1011, 1'b0, 5'd2, 32'h40, 4'b1000};
        tbl[16] = '{4'b1011, 1'b0, 5'd2, 32'h40, 4'b0001};
        tbl[17] = '{4'b1011, 1'b0, 5'd2, 32'h40, 4'b0010};
        tbl[18] = '{4'b0000, 1'b0, 5'd2, 32'h40, 4'b0000};

        // Reset: outputs zero and requests ignored while reset is held.
        arst_ni = 1'b0;
        apply(4'b1111, 1'b0, 5'd5, 32'h0A);
        #3;
        check("rst_ready", 64'(src_ready_o), 64'(0));
        check("rst_en",    64'(wr_unlock_en_o), 64'(0));
        check("rst_addr",  64'(wr_unlock_addr_o), 64'(0));
        check("rst_data",  64'(wr_unlock_data_o), 64'(0));
        check("rst_idx",   64'(grant_idx_o), 64'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("rst_en_clk", 64'(wr_unlock_en_o), 64'(0));
        arst_ni = 1'b1;

        for (int n = 0; n < 19; n++) run_vec(tbl[n], n);
        #1;
        pop_compare("vec_last");

        // Async reset while a write is being presented.
        apply(4'b0100, 1'b0, 5'd7, 32'h53);
        #2;
        check("ar_ready", 64'(src_ready_o), 64'(4'b0100));
        @(posedge clk_i);
        #1;
        check("ar_en_pre",   64'(wr_unlock_en_o), 64'(1));
        check("ar_addr_pre", 64'(wr_unlock_addr_o), 64'(7));
        check("ar_data_pre", 64'(wr_unlock_data_o), 64'(32'h55));
        apply(4'b1111, 1'b0, 5'd6, 32'h60);
        #1;
        arst_ni = 1'b0;
        #1;
        check("ar_en",    64'(wr_unlock_en_o), 64'(0));
        check("ar_addr",  64'(wr_unlock_addr_o), 64'(0));
        check("ar_data",  64'(wr_unlock_data_o), 64'(0));
        check("ar_ready_low", 64'(src_ready_o), 64'(0));
        #1;
        arst_ni = 1'b1;
        #2;
        check("ar_rel_ready", 64'(src_ready_o), 64'(4'b0001));
        check("ar_rel_idx",   64'(grant_idx_o), 64'(0));
        @(posedge clk_i);
        #1;
        check("ar_rel_en",   64'(wr_unlock_en_o), 64'(1));
        check("ar_rel_addr", 64'(wr_unlock_addr_o), 64'(6));
        check("ar_rel_data", 64'(wr_unlock_data_o), 64'(32'h60));
        last_addr = 5'd6; last_data = 32'h60; last_known = 1'b1;
        ptr = 1;

        // Random phase: requesters hold until accepted; model predicts grants.
        rv = '0;
        max_wait = 0;
        for (int i = 0; i < NS; i++) begin ra[i] = '0; rd[i] = '0; wt[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            logic [NS-1:0] g;
            logic [SW-1:0] gi;
            for (int i = 0; i < NS; i++) begin
                if (!rv[i] && ($urandom_range(1, 0) == 1)) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(31, 0));
                    rd[i] = $urandom;
                    wt[i] = 0;
                end
            end
            src_valid_i = rv;
            flush_i     = 1'b0;
            for (int i = 0; i < NS; i++) begin
                src_addr_i[i] = ra[i];
                src_data_i[i] = rd[i];
            end
            #1;
            if (sb_q.size() != 0) pop_compare("rnd");
            #2;
            g  = model_gnt(rv, ptr);
            gi = onehot_idx(g);
            check("rnd_ready", 64'(src_ready_o), 64'(g));
            check("rnd_onehot", 64'($onehot0(src_ready_o)), 64'(1));
            if (g != '0) begin
                check("rnd_idx", 64'(grant_idx_o), 64'(gi));
                ptr = (32'(gi) + 1) % NS;
            end
            push_expect(g, ra[gi], rd[gi]);
            for (int i = 0; i < NS; i++) begin
                if (rv[i]) begin
                    if (g[i]) begin
                        if (wt[i] + 1 > max_wait) max_wait = wt[i] + 1;
                        rv[i] = 1'b0;
                    end else begin
                        wt[i]++;
                    end
                end
            end
            @(posedge clk_i);
            #1;
        end
        #1;
        pop_compare("rnd_last");
        check("rnd_starvation", 64'(max_wait <= NS), 64'(1));
        check("rnd_max_wait_seen", 64'(max_wait >= 2), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_arbiter
